// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit order and active-low glyphs.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Patterns are {a,b,c,d,e,f,g}; a 0 bit lights the segment.
    localparam logic [6:0] GLYPH_0    = 7'b0000001;
    localparam logic [6:0] GLYPH_1    = 7'b1001111;
    localparam logic [6:0] GLYPH_2    = 7'b0010010;
    localparam logic [6:0] GLYPH_3    = 7'b0000110;
    localparam logic [6:0] GLYPH_4    = 7'b1001100;
    localparam logic [6:0] GLYPH_5    = 7'b0100100;
    localparam logic [6:0] GLYPH_6    = 7'b0100000;
    localparam logic [6:0] GLYPH_7    = 7'b0001101;
    localparam logic [6:0] GLYPH_8    = 7'b0000000;
    localparam logic [6:0] GLYPH_9    = 7'b0000100;
    localparam logic [6:0] GLYPH_A    = 7'b0001000;
    localparam logic [6:0] GLYPH_B    = 7'b1100000;
    localparam logic [6:0] GLYPH_C    = 7'b0110001;
    localparam logic [6:0] GLYPH_D    = 7'b1000010;
    localparam logic [6:0] GLYPH_E    = 7'b0110000;
    localparam logic [6:0] GLYPH_F    = 7'b0111000;
    localparam logic [6:0] GLYPH_DASH = 7'b1111110;
    localparam logic [6:0] GLYPH_OFF  = 7'b1111111;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational digit-code to segment decoder; codes 10-15 show letters or a dash.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_OFF;
        case (code)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = hex_en ? GLYPH_A : GLYPH_DASH;
            4'hB: seg = hex_en ? GLYPH_B : GLYPH_DASH;
            4'hC: seg = hex_en ? GLYPH_C : GLYPH_DASH;
            4'hD: seg = hex_en ? GLYPH_D : GLYPH_DASH;
            4'hE: seg = hex_en ? GLYPH_E : GLYPH_DASH;
            4'hF: seg = hex_en ? GLYPH_F : GLYPH_DASH;
            default: seg = GLYPH_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display driver with frame-aligned digit capture,
// per-digit blank/blink and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 1000,
    parameter int BLINK_DIV  = 500000,
    parameter int HEX_EN     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic                    load_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    input  logic                    lzs_en_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic                    frame_o
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [SW-1:0]         scan_cnt;
    logic [BW-1:0]         blink_cnt;
    logic [IW-1:0]         idx;
    logic                  blink_phase;
    logic [DW-1:0]         shadow;
    logic [DW-1:0]         pending;
    logic                  pend;

    logic                  frame_end;
    logic [NUM_DIGITS-1:0] lzs_mask;
    logic                  zero_above;
    logic [3:0]            cur_code;
    logic                  cur_blank;
    logic                  cur_blink;
    logic                  cur_lzs;
    logic [6:0]            glyph_seg;
    logic [6:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign frame_end = (scan_cnt == SCAN_LAST) && (idx == IDX_LAST);

    // A digit is suppressed only when it and every more significant digit are zero.
    always_comb begin
        lzs_mask   = '0;
        zero_above = lzs_en_i;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above  = zero_above && (shadow[4*k +: 4] == 4'h0);
            lzs_mask[k] = zero_above;
        end
    end

    always_comb begin
        cur_code  = 4'h0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_lzs   = 1'b0;
        an_next   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                cur_code  = shadow[4*k +: 4];
                cur_blank = blank_i[k];
                cur_blink = blink_i[k];
                cur_lzs   = lzs_mask[k];
                an_next[k] = (scan_cnt == '0);
            end
        end
    end

    seg7_glyph u_glyph (
        .code   (cur_code),
        .hex_en (HEX_EN != 0),
        .seg    (glyph_seg)
    );

    assign seg_next = (cur_blank || (cur_blink && !blink_phase) || cur_lzs) ? GLYPH_OFF : glyph_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt    <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            shadow      <= '0;
            pending     <= '0;
            pend        <= 1'b0;
            seg_o       <= GLYPH_OFF;
            an_o        <= '1;
            frame_o     <= 1'b0;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            // A load landing exactly on the frame end goes straight to the display.
            if (frame_end) begin
                if (load_i) begin
                    shadow <= digits_i;
                end else if (pend) begin
                    shadow <= pending;
                end
                pend <= 1'b0;
            end else if (load_i) begin
                pending <= digits_i;
                pend    <= 1'b1;
            end

            frame_o <= frame_end;
            seg_o   <= seg_next;
            an_o    <= an_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench: stimulus queues expected per-slot {an,seg}; monitors pop on each lit-slot start.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] digits = 12'h000;
    logic        load = 1'b0;
    logic [2:0]  blank = 3'b000;
    logic [2:0]  blink = 3'b000;
    logic        lzs = 1'b0;
    logic [6:0]  seg, seg2;
    logic [2:0]  an, an2;
    logic        frame, frame2;

    int checks = 0;
    int errors = 0;
    int e = 0;
    logic [9:0] q1[$];
    logic [9:0] q2[$];
    logic [2:0] prev1 = 3'b111;
    logic [2:0] prev2 = 3'b111;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(16), .HEX_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .digits_i(digits), .load_i(load), .blank_i(blank),
        .blink_i(blink), .lzs_en_i(lzs), .seg_o(seg), .an_o(an), .frame_o(frame)
    );

    seg7_scan_driver #(.NUM_DIGITS(3), .SCAN_DIV(4), .BLINK_DIV(16), .HEX_EN(0)) dut_nohex (
        .clk(clk), .rst_n(rst_n), .digits_i(digits), .load_i(load), .blank_i(blank),
        .blink_i(blink), .lzs_en_i(lzs), .seg_o(seg2), .an_o(an2), .frame_o(frame2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        @(negedge clk);
    endtask

    task automatic step_to(input int t);
        while (e < t) step();
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
        q1.push_back({3'b110, s0});
        q1.push_back({3'b101, s1});
        q1.push_back({3'b011, s2});
    endtask

    always @(negedge clk) begin : mon_main
        logic [9:0] x;
        if (rst_n) begin
            chk("an_single_low", 32'(($countones(~an) > 1) ? 1 : 0), 32'd0);
            if (prev1 == 3'b111 && an != 3'b111 && q1.size() > 0) begin
                x = q1.pop_front();
                chk("slot_an", 32'(an), 32'(x[9:7]));
                chk("slot_seg", 32'(seg), 32'(x[6:0]));
            end
        end
        prev1 = an;
    end

    always @(negedge clk) begin : mon_nohex
        logic [9:0] x;
        if (rst_n) begin
            if (prev2 == 3'b111 && an2 != 3'b111 && q2.size() > 0) begin
                x = q2.pop_front();
                chk("nohex_an", 32'(an2), 32'(x[9:7]));
                chk("nohex_seg", 32'(seg2), 32'(x[6:0]));
            end
        end
        prev2 = an2;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at %0t, expected completion", $time);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        digits = 12'h123;
        load   = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_seg", 32'(seg), 32'(GLYPH_OFF));
        chk("reset_an", 32'(an), 32'h7);
        chk("reset_frame", 32'(frame), 32'h0);

        // Frame 0 still shows the reset shadow; 0x123 is pending until edge 12.
        push_frame(GLYPH_0, GLYPH_0, GLYPH_0);
        rst_n = 1'b1;
        e = 0;
        step();
        load = 1'b0;

        step_to(11);
        chk("frame_idle", 32'(frame), 32'h0);
        step();
        chk("frame_pulse", 32'(frame), 32'h1);
        chk("last_slot_an", 32'(an), 32'h3);
        push_frame(GLYPH_3, GLYPH_2, GLYPH_1);
        step();
        chk("frame_clear", 32'(frame), 32'h0);
        chk("guard_an", 32'(an), 32'h7);

        // Two loads within frame 1: display holds 123, then only 789 appears.
        step_to(16); digits = 12'h456; load = 1'b1; step(); load = 1'b0;
        step_to(19); digits = 12'h789; load = 1'b1; step(); load = 1'b0;
        step_to(24);
        chk("frame_pulse2", 32'(frame), 32'h1);
        push_frame(GLYPH_9, GLYPH_8, GLYPH_7);

        // Load on the frame-end cycle bypasses the pending register.
        step_to(35); digits = 12'h005; load = 1'b1; step(); load = 1'b0;
        chk("frame_bypass", 32'(frame), 32'h1);
        lzs = 1'b1;
        push_frame(GLYPH_5, GLYPH_OFF, GLYPH_OFF);

        step_to(39); digits = 12'h000; load = 1'b1; step(); load = 1'b0;
        step_to(48);
        push_frame(GLYPH_0, GLYPH_OFF, GLYPH_OFF);

        step_to(60);
        lzs = 1'b0;
        push_frame(GLYPH_0, GLYPH_0, GLYPH_0);
        digits = 12'hFCB; load = 1'b1; step(); load = 1'b0;

        step_to(72);
        push_frame(GLYPH_B, GLYPH_C, GLYPH_F);
        q2.push_back({3'b110, GLYPH_DASH});
        q2.push_back({3'b101, GLYPH_DASH});
        q2.push_back({3'b011, GLYPH_DASH});

        // Blink phase before edge n is visible when (n-1)/16 is even; digit 0 slot starts at edge 86,98,110,122.
        step_to(84);
        blink = 3'b001;
        push_frame(GLYPH_OFF, GLYPH_C, GLYPH_F);
        push_frame(GLYPH_B, GLYPH_C, GLYPH_F);
        push_frame(GLYPH_B, GLYPH_C, GLYPH_F);
        push_frame(GLYPH_OFF, GLYPH_C, GLYPH_F);

        // Blank overrides a visible blink phase (edge 134) and an invisible one (edge 146).
        step_to(132);
        blank = 3'b001;
        push_frame(GLYPH_OFF, GLYPH_C, GLYPH_F);
        push_frame(GLYPH_OFF, GLYPH_C, GLYPH_F);

        step_to(156);
        blank = 3'b000;
        blink = 3'b000;
        step_to(157); digits = 12'h777; load = 1'b1; step(); load = 1'b0;
        chk("mid_slot_an", 32'(an), 32'h6);
        chk("mid_slot_seg", 32'(seg), 32'(GLYPH_B));

        // Reset mid-slot with a load pending: outputs go dark at once and 777 never appears.
        rst_n = 1'b0;
        #1;
        chk("rst_seg", 32'(seg), 32'(GLYPH_OFF));
        chk("rst_an", 32'(an), 32'h7);
        chk("rst_frame", 32'(frame), 32'h0);
        @(negedge clk);
        push_frame(GLYPH_0, GLYPH_0, GLYPH_0);
        push_frame(GLYPH_0, GLYPH_0, GLYPH_0);
        rst_n = 1'b1;
        e = 0;
        step_to(12);
        chk("frame_after_rst", 32'(frame), 32'h1);
        step_to(26);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
